// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types for the pipeline hazard controller: FSM state encoding,
//   the bundle of per-register pipeline controls, and helpers that build
//   and resolve that bundle.
package hazard_ctrl_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DMEM_WAIT  = 2'd1,
        ST_REDIR_PEND = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    // One bit per pipeline control output, in the order they reach the datapath.
    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_bubble;
        logic ex_mem_hold;
        logic redirect;
        logic halted;
    } ctrl_t;

    // Every pipeline register keeps its value; nothing is flushed.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c             = '0;
        c.pc_hold     = 1'b1;
        c.if_id_hold  = 1'b1;
        c.id_ex_hold  = 1'b1;
        c.ex_mem_hold = 1'b1;
        return c;
    endfunction

    // A register told to both keep and clear must clear.
    function automatic ctrl_t ctrl_resolve(input ctrl_t c);
        ctrl_t r;
        r            = c;
        r.if_id_hold = c.if_id_hold & ~c.if_id_flush;
        r.id_ex_hold = c.id_ex_hold & ~c.id_ex_bubble;
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the datapath-side status inputs and pipeline-control outputs of
//   hazard_ctrl.
//   master: datapath / testbench (drives i_*, observes o_*)
//   slave : hazard_ctrl          (observes i_*, drives o_*)
interface hazard_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
);
    logic               i_id_valid;
    logic [RADDR_W-1:0] i_id_rs1;
    logic [RADDR_W-1:0] i_id_rs2;
    logic               i_id_rs1_used;
    logic               i_id_rs2_used;
    logic               i_ex_valid;
    logic               i_ex_mem_read;
    logic [RADDR_W-1:0] i_ex_rd;
    logic               i_ex_redirect;
    logic [XLEN-1:0]    i_ex_target;
    logic               i_mem_req;
    logic               i_dmem_ready;
    logic               i_imem_ready;
    logic               i_wb_halt;

    logic               o_pc_hold;
    logic               o_if_id_hold;
    logic               o_if_id_flush;
    logic               o_id_ex_hold;
    logic               o_id_ex_bubble;
    logic               o_ex_mem_hold;
    logic               o_redirect;
    logic [XLEN-1:0]    o_redirect_pc;
    logic               o_halted;
    logic [CNT_W-1:0]   o_stall_cnt;
    logic [CNT_W-1:0]   o_flush_cnt;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_ex_valid, i_ex_mem_read, i_ex_rd, i_ex_redirect, i_ex_target,
               i_mem_req, i_dmem_ready, i_imem_ready, i_wb_halt,
        input  o_pc_hold, o_if_id_hold, o_if_id_flush, o_id_ex_hold, o_id_ex_bubble,
               o_ex_mem_hold, o_redirect, o_redirect_pc, o_halted, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_ex_valid, i_ex_mem_read, i_ex_rd, i_ex_redirect, i_ex_target,
               i_mem_req, i_dmem_ready, i_imem_ready, i_wb_halt,
        output o_pc_hold, o_if_id_hold, o_if_id_flush, o_id_ex_hold, o_id_ex_bubble,
               o_ex_mem_hold, o_redirect, o_redirect_pc, o_halted, o_stall_cnt, o_flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect
//   Combinational load-use comparator. Flags when the load in EX writes a
//   register the instruction in ID actually reads. x0 never creates a hazard.
//   Ports: ID valid/sources/used flags, EX valid/mem_read/rd in;
//          o_load_use out.
module hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_rs1_used,
    input  logic               i_id_rs2_used,
    input  logic               i_ex_valid,
    input  logic               i_ex_mem_read,
    input  logic [RADDR_W-1:0] i_ex_rd,
    output logic               o_load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign rs2_hit    = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0) &
                        i_id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Stall/flush scheduler for the 5-stage RV32I pipeline. Detects load-use
//   hazards, sequences control-transfer redirects (holding the target while
//   imem is busy), freezes the pipe during dmem waits, and parks it on halt.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     bus (slave)  : ID/EX/MEM/WB status in; hold/flush/bubble/redirect
//                    controls, halted flag and stall/flush counters out
//   Controls are combinational from state + inputs; state, latched target
//   and counters are registered.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    hazard_ctrl_if.slave bus
);
    state_t           state, state_nxt;
    ctrl_t            ctl_raw, ctl;
    logic [XLEN-1:0]  tgt_q;
    logic [XLEN-1:0]  rpc_raw, rpc;
    logic             tgt_load;
    logic             load_use;
    logic             dmem_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_detect #(.RADDR_W(RADDR_W)) u_detect (
        .i_id_valid    (bus.i_id_valid),
        .i_id_rs1      (bus.i_id_rs1),
        .i_id_rs2      (bus.i_id_rs2),
        .i_id_rs1_used (bus.i_id_rs1_used),
        .i_id_rs2_used (bus.i_id_rs2_used),
        .i_ex_valid    (bus.i_ex_valid),
        .i_ex_mem_read (bus.i_ex_mem_read),
        .i_ex_rd       (bus.i_ex_rd),
        .o_load_use    (load_use)
    );

    assign dmem_busy = bus.i_mem_req & ~bus.i_dmem_ready;

    always_comb begin
        ctl_raw   = '0;
        rpc_raw   = '0;
        tgt_load  = 1'b0;
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (bus.i_wb_halt) begin
                    ctl_raw   = ctrl_freeze();
                    state_nxt = ST_HALTED;
                end else if (dmem_busy) begin
                    ctl_raw   = ctrl_freeze();
                    state_nxt = ST_DMEM_WAIT;
                end else if (bus.i_ex_redirect) begin
                    ctl_raw.if_id_flush  = 1'b1;
                    ctl_raw.id_ex_bubble = 1'b1;
                    rpc_raw              = bus.i_ex_target;
                    if (bus.i_imem_ready) begin
                        ctl_raw.redirect = 1'b1;
                    end else begin
                        // Fetch cannot take the new PC yet; park it.
                        ctl_raw.pc_hold = 1'b1;
                        tgt_load        = 1'b1;
                        state_nxt       = ST_REDIR_PEND;
                    end
                end else if (load_use) begin
                    ctl_raw.pc_hold      = 1'b1;
                    ctl_raw.if_id_hold   = 1'b1;
                    ctl_raw.id_ex_bubble = 1'b1;
                end else if (!bus.i_imem_ready) begin
                    // Fetch bubble: nothing valid enters IF/ID.
                    ctl_raw.pc_hold     = 1'b1;
                    ctl_raw.if_id_flush = 1'b1;
                end
            end
            ST_DMEM_WAIT: begin
                if (bus.i_wb_halt) begin
                    ctl_raw   = ctrl_freeze();
                    state_nxt = ST_HALTED;
                end else if (!bus.i_dmem_ready) begin
                    ctl_raw = ctrl_freeze();
                end else begin
                    // Release cycle; a redirect still sitting in EX is
                    // picked up from RUN.
                    state_nxt = ST_RUN;
                end
            end
            ST_REDIR_PEND: begin
                if (bus.i_wb_halt) begin
                    ctl_raw   = ctrl_freeze();
                    state_nxt = ST_HALTED;
                end else begin
                    // EX holds a bubble here, so any i_ex_redirect is ignored.
                    rpc_raw             = tgt_q;
                    ctl_raw.if_id_flush = 1'b1;
                    if (dmem_busy) begin
                        ctl_raw.id_ex_hold  = 1'b1;
                        ctl_raw.ex_mem_hold = 1'b1;
                    end
                    if (bus.i_imem_ready) begin
                        ctl_raw.redirect = 1'b1;
                        state_nxt        = ST_RUN;
                    end else begin
                        ctl_raw.pc_hold = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                ctl_raw        = ctrl_freeze();
                ctl_raw.halted = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase

        ctl = ctrl_resolve(ctl_raw);
        rpc = rpc_raw;
        // Outputs read as idle while reset is asserted.
        if (i_rst) begin
            ctl = '0;
            rpc = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RUN;
            tgt_q     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            if (tgt_load) tgt_q <= bus.i_ex_target;
            stall_cnt <= stall_cnt + CNT_W'(ctl.pc_hold);
            flush_cnt <= flush_cnt + CNT_W'(ctl.if_id_flush);
        end
    end

    assign bus.o_pc_hold      = ctl.pc_hold;
    assign bus.o_if_id_hold   = ctl.if_id_hold;
    assign bus.o_if_id_flush  = ctl.if_id_flush;
    assign bus.o_id_ex_hold   = ctl.id_ex_hold;
    assign bus.o_id_ex_bubble = ctl.id_ex_bubble;
    assign bus.o_ex_mem_hold  = ctl.ex_mem_hold;
    assign bus.o_redirect     = ctl.redirect;
    assign bus.o_redirect_pc  = rpc;
    assign bus.o_halted       = ctl.halted;
    assign bus.o_stall_cnt    = stall_cnt;
    assign bus.o_flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed vectors for hazard_ctrl. Each applied vector pushes its
//   hand-computed expected controls into a scoreboard queue; a monitor on
//   the falling edge pops and compares against the DUT outputs.
//   Control byte: {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
//                  id_ex_bubble, ex_mem_hold, redirect, halted}
module tb_hazard_ctrl;

    logic clk;
    logic rst;

    hazard_ctrl_if #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) bus ();

    hazard_ctrl #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [7:0]  ctl;
        logic [31:0] pc;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_vec  = 0;
    int          n_err  = 0;
    logic [31:0] e_stall = 0;
    logic [31:0] e_flush = 0;
    logic [7:0]  act;
    logic        bad;

    localparam logic [7:0] C_IDLE  = 8'h00;
    localparam logic [7:0] C_FRZ   = 8'hD4; // pc, if_id, id_ex, ex_mem holds
    localparam logic [7:0] C_HALT  = 8'hD5; // freeze + halted
    localparam logic [7:0] C_LU    = 8'hC8; // pc_hold, if_id_hold, id_ex_bubble
    localparam logic [7:0] C_RDIR  = 8'h2A; // flush, bubble, redirect
    localparam logic [7:0] C_RPEN0 = 8'hA8; // pc_hold, flush, bubble
    localparam logic [7:0] C_RPEN  = 8'hA0; // pc_hold, flush
    localparam logic [7:0] C_RPDM  = 8'hB4; // pending + EX/MEM frozen
    localparam logic [7:0] C_RGO   = 8'h22; // flush, redirect
    localparam logic [7:0] C_IMEM  = 8'hA0; // fetch bubble

    task automatic idle();
        rst               = 1'b0;
        bus.i_id_valid    = 1'b0;
        bus.i_id_rs1      = '0;
        bus.i_id_rs2      = '0;
        bus.i_id_rs1_used = 1'b0;
        bus.i_id_rs2_used = 1'b0;
        bus.i_ex_valid    = 1'b0;
        bus.i_ex_mem_read = 1'b0;
        bus.i_ex_rd       = '0;
        bus.i_ex_redirect = 1'b0;
        bus.i_ex_target   = '0;
        bus.i_mem_req     = 1'b0;
        bus.i_dmem_ready  = 1'b1;
        bus.i_imem_ready  = 1'b1;
        bus.i_wb_halt     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Push expectation for the inputs just driven; advance the counter model.
    task automatic expect_v(input string nm, input logic [7:0] c, input logic [31:0] pc);
        exp_t e;
        e.nm    = nm;
        e.ctl   = c;
        e.pc    = pc;
        e.stall = e_stall;
        e.flush = e_flush;
        sb.push_back(e);
        if (rst) begin
            e_stall = 0;
            e_flush = 0;
        end else begin
            e_stall = e_stall + 32'(c[7]);
            e_flush = e_flush + 32'(c[5]);
        end
    endtask

    task automatic load_use_setup(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic u1, input logic [4:0] rs2, input logic u2);
        bus.i_ex_valid    = 1'b1;
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rd       = rd;
        bus.i_id_valid    = 1'b1;
        bus.i_id_rs1      = rs1;
        bus.i_id_rs1_used = u1;
        bus.i_id_rs2      = rs2;
        bus.i_id_rs2_used = u2;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me  = sb.pop_front();
            act = {bus.o_pc_hold, bus.o_if_id_hold, bus.o_if_id_flush, bus.o_id_ex_hold,
                   bus.o_id_ex_bubble, bus.o_ex_mem_hold, bus.o_redirect, bus.o_halted};
            bad = 1'b0;
            n_vec++;
            if (act !== me.ctl) begin
                $display("FAIL %s ctl: got %b want %b", me.nm, act, me.ctl);
                bad = 1'b1;
            end
            if (bus.o_redirect_pc !== me.pc) begin
                $display("FAIL %s redirect_pc: got %h want %h", me.nm, bus.o_redirect_pc, me.pc);
                bad = 1'b1;
            end
            if (bus.o_stall_cnt !== me.stall) begin
                $display("FAIL %s stall_cnt: got %0d want %0d", me.nm, bus.o_stall_cnt, me.stall);
                bad = 1'b1;
            end
            if (bus.o_flush_cnt !== me.flush) begin
                $display("FAIL %s flush_cnt: got %0d want %0d", me.nm, bus.o_flush_cnt, me.flush);
                bad = 1'b1;
            end
            if (bad) n_err++;
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, even with an input that would otherwise stall fetch.
        #1; rst = 1'b1; bus.i_imem_ready = 1'b0;
        expect_v("reset", C_IDLE, 32'h0);
        cyc(); expect_v("idle", C_IDLE, 32'h0);

        // 1: lw x5 in EX, add reads x5 in ID -> one bubble cycle.
        cyc(); load_use_setup(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        expect_v("lu_rs1", C_LU, 32'h0);
        cyc(); bus.i_id_valid = 1'b1; bus.i_id_rs1 = 5'd5; bus.i_id_rs1_used = 1'b1;
        expect_v("lu_after", C_IDLE, 32'h0);

        // 2: no hazard on x0 or on an unused source; rs2 match does stall.
        cyc(); load_use_setup(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        expect_v("lu_rd0", C_IDLE, 32'h0);
        cyc(); load_use_setup(5'd5, 5'd5, 1'b0, 5'd3, 1'b1);
        expect_v("lu_unused", C_IDLE, 32'h0);
        cyc(); load_use_setup(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        expect_v("lu_rs2", C_LU, 32'h0);
        cyc(); load_use_setup(5'd7, 5'd7, 1'b1, 5'd7, 1'b1); bus.i_ex_valid = 1'b0;
        expect_v("lu_ex_inval", C_IDLE, 32'h0);

        // 3: redirect with imem ready, same-cycle.
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h100;
        expect_v("redir_now", C_RDIR, 32'h100);
        cyc(); expect_v("redir_cnt", C_IDLE, 32'h0);

        // 4: redirect to 0x200 while imem busy for 3 cycles.
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h200; bus.i_imem_ready = 1'b0;
        expect_v("rpend0", C_RPEN0, 32'h200);
        cyc(); bus.i_imem_ready = 1'b0; bus.i_ex_target = 32'hDEAD;
        expect_v("rpend1", C_RPEN, 32'h200);
        cyc(); bus.i_imem_ready = 1'b0; bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h999;
        expect_v("rpend2_ign", C_RPEN, 32'h200);
        cyc(); expect_v("rpend_go", C_RGO, 32'h200);
        cyc(); expect_v("rpend_done", C_IDLE, 32'h0);

        // 5: dmem wait beats a pending redirect and a load-use.
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.i_mem_req = 1'b1; bus.i_dmem_ready = 1'b0;
            bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h300;
            load_use_setup(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
            expect_v("dmem_frz", C_FRZ, 32'h0);
        end
        cyc(); bus.i_mem_req = 1'b1; bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h300;
        expect_v("dmem_rel", C_IDLE, 32'h0);
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h300;
        expect_v("dmem_redir", C_RDIR, 32'h300);

        // Pending redirect with dmem busy: EX/MEM frozen, fetch still flushed.
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h400; bus.i_imem_ready = 1'b0;
        expect_v("rpdm0", C_RPEN0, 32'h400);
        cyc(); bus.i_imem_ready = 1'b0; bus.i_mem_req = 1'b1; bus.i_dmem_ready = 1'b0;
        expect_v("rpdm1", C_RPDM, 32'h400);
        cyc(); bus.i_mem_req = 1'b1;
        expect_v("rpdm_go", C_RGO, 32'h400);

        // imem wait alone.
        cyc(); bus.i_imem_ready = 1'b0;
        expect_v("imem_wait", C_IMEM, 32'h0);

        // Reset mid-pending discards the latched target.
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h500; bus.i_imem_ready = 1'b0;
        expect_v("rst_pend0", C_RPEN0, 32'h500);
        cyc(); rst = 1'b1; bus.i_imem_ready = 1'b0;
        expect_v("rst_pend", C_IDLE, 32'h0);
        cyc(); bus.i_imem_ready = 1'b0;
        expect_v("rst_pend_run", C_IMEM, 32'h0);

        // 6: halt, then 10 parked cycles regardless of inputs, then reset.
        cyc(); bus.i_wb_halt = 1'b1;
        expect_v("halt_enter", C_FRZ, 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc(); bus.i_ex_redirect = i[0]; bus.i_ex_target = 32'h600;
            bus.i_imem_ready = i[1];
            expect_v("halted", C_HALT, 32'h0);
        end
        cyc(); rst = 1'b1;
        expect_v("halt_rst", C_IDLE, 32'h0);
        cyc(); expect_v("post_rst", C_IDLE, 32'h0);
        cyc(); bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h700;
        expect_v("post_rst_run", C_RDIR, 32'h700);

        cyc();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: got %0d pending want 0", sb.size());
            n_err++;
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
